// File: rtl/banked_regfile.sv
// banked_regfile: multi-bank register file with bank-copy FSM; ports clock/reset, CPU path (bank_sel, rd_addr, rs_addr, w_data, w_en -> rd_data, rs_data), copy path (copy_req, copy_src, copy_dst -> copy_busy, copy_done); define REGFILE_BYPASS_EN to forward w_data to rs_data
module banked_regfile #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int BANK_W = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [BANK_W-1:0] bank_sel,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              w_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] rs_data,
  input  logic              copy_req,
  input  logic [BANK_W-1:0] copy_src,
  input  logic [BANK_W-1:0] copy_dst,
  output logic              copy_busy,
  output logic              copy_done
);
  localparam int NREG = 1 << ADDR_W;
  localparam int NBANK = 1 << BANK_W;
  typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;
  state_t state;
  logic [DATA_W-1:0] regs [NBANK][NREG];
  logic [BANK_W-1:0] src, dst;
  logic [ADDR_W:0] idx;
  logic last;
  assign last = idx == (ADDR_W+1)'(NREG - 1);
  assign rd_data = regs[bank_sel][rd_addr];
`ifdef REGFILE_BYPASS_EN
  assign rs_data = (w_en && rs_addr == rd_addr) ? w_data : regs[bank_sel][rs_addr];
`else
  assign rs_data = regs[bank_sel][rs_addr];
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int b = 0; b < NBANK; b++)
        for (int r = 0; r < NREG; r++)
          regs[b][r] <= '0;
      state <= IDLE;
      idx <= '0;
      src <= '0;
      dst <= '0;
      copy_busy <= 1'b0;
      copy_done <= 1'b0;
    end else begin
      copy_done <= 1'b0;
      if (state == IDLE && copy_req) begin
        src <= copy_src;
        dst <= copy_dst;
        idx <= '0;
        state <= (copy_src != copy_dst) ? COPY : DONE;
        copy_busy <= 1'b1;
        copy_done <= copy_src == copy_dst;
      end else if (state == COPY) begin
        regs[dst][idx[ADDR_W-1:0]] <= regs[src][idx[ADDR_W-1:0]];
        idx <= idx + (ADDR_W+1)'(1);
        state <= last ? DONE : COPY;
        copy_done <= last;
      end else if (state == DONE) begin
        state <= IDLE;
        copy_busy <= 1'b0;
      end
      // placed after the copy write so a colliding CPU write takes priority
      if (w_en) regs[bank_sel][rd_addr] <= w_data;
    end
  end
endmodule

// File: tb/tb_banked_regfile.sv
// tb_banked_regfile: directed and randomized checks of banked_regfile against a count-based reference model
module tb_banked_regfile;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       bank_sel = 1'b0;
  logic [1:0] rd_addr = '0;
  logic [1:0] rs_addr = '0;
  logic [7:0] w_data = '0;
  logic       w_en = 1'b0;
  logic [7:0] rd_data, rs_data;
  logic       copy_req = 1'b0;
  logic       copy_src = 1'b0;
  logic       copy_dst = 1'b0;
  logic       copy_busy, copy_done;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] m [2][4];
  int m_left;
  bit m_done;
  bit m_src, m_dst;
  banked_regfile dut (
    .clock(clock), .reset(reset), .bank_sel(bank_sel), .rd_addr(rd_addr), .rs_addr(rs_addr),
    .w_data(w_data), .w_en(w_en), .rd_data(rd_data), .rs_data(rs_data), .copy_req(copy_req),
    .copy_src(copy_src), .copy_dst(copy_dst), .copy_busy(copy_busy), .copy_done(copy_done)
  );
  always #5 clock = ~clock;
  function automatic logic [7:0] exp_rs();
`ifdef REGFILE_BYPASS_EN
    if (w_en && rs_addr == rd_addr) return w_data;
`endif
    return m[bank_sel][rs_addr];
  endfunction
  task automatic step();
    logic [7:0] nx [2][4];
    bit nd;
    int pos;
    @(posedge clock);
    if (reset) begin
      for (int b = 0; b < 2; b++) for (int r = 0; r < 4; r++) m[b][r] = '0;
      m_left = 0;
      m_done = 0;
    end else begin
      nx = m;
      nd = 0;
      if (m_left > 0) begin
        pos = 4 - m_left;
        nx[m_dst][pos] = m[m_src][pos];
        m_left--;
        nd = (m_left == 0);
      end else if (!m_done && copy_req) begin
        if (copy_src != copy_dst) begin
          m_src = copy_src;
          m_dst = copy_dst;
          m_left = 4;
        end else nd = 1;
      end
      if (w_en) nx[bank_sel][rd_addr] = w_data;
      m = nx;
      m_done = nd;
    end
    #1;
  endtask
  task automatic wr(input bit b, input logic [1:0] a, input logic [7:0] d);
    bank_sel = b; rd_addr = a; w_data = d; w_en = 1'b1;
    step();
    w_en = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 4; a++) begin
        bank_sel = b[0]; rd_addr = a[1:0]; rs_addr = 2'(3 - a);
        #1;
        n_chk++;
        if (rd_data !== 8'h00 || rs_data !== 8'h00 || copy_busy !== 1'b0 || copy_done !== 1'b0) begin
          n_fail++;
          $display("FAIL reset b%0d a%0d: rd=%h rs=%h busy=%b done=%b, want 00 00 0 0", b, a, rd_data, rs_data, copy_busy, copy_done);
        end
      end
  endtask
  task automatic test_bank_write();
    wr(0, 1, 8'h5A);
    wr(1, 1, 8'hC3);
    for (int b = 0; b < 2; b++) begin
      bank_sel = b[0]; rd_addr = 1; rs_addr = 1;
      #1;
      n_chk++;
      if (rd_data !== (b ? 8'hC3 : 8'h5A) || rs_data !== rd_data) begin
        n_fail++;
        $display("FAIL bank_write b%0d: rd=%h rs=%h, want %h", b, rd_data, rs_data, b ? 8'hC3 : 8'h5A);
      end
    end
  endtask
  task automatic test_copy(input bit collide);
    int busy_cnt, done_cnt, done_at;
    logic [7:0] want [4];
    want = '{8'h11, 8'h22, collide ? 8'hEE : 8'h33, 8'h44};
    for (int a = 0; a < 4; a++) wr(0, a[1:0], 8'(17 * (a + 1)));
    copy_req = 1'b1; copy_src = 1'b0; copy_dst = 1'b1;
    step();
    copy_req = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int k = 1; k <= 9; k++) begin
      if (collide && k == 2) begin copy_req = 1'b1; copy_src = 1'b0; copy_dst = 1'b0; end
      if (collide && k == 3) begin copy_req = 1'b0; bank_sel = 1'b1; rd_addr = 2; w_data = 8'hEE; w_en = 1'b1; end
      if (k == 4) w_en = 1'b0;
      #1;
      if (copy_busy === 1'b1) busy_cnt++;
      if (copy_done === 1'b1) begin done_cnt++; done_at = k; end
      step();
    end
    copy_req = 1'b0;
    n_chk++;
    if (busy_cnt != 5 || done_cnt != 1 || done_at != 5) begin
      n_fail++;
      $display("FAIL copy_timing c%0d: busy=%0d done=%0d at=%0d, want 5 1 5", collide, busy_cnt, done_cnt, done_at);
    end
    for (int a = 0; a < 4; a++) begin
      bank_sel = 1'b1; rd_addr = a[1:0];
      #1;
      n_chk++;
      if (rd_data !== want[a]) begin
        n_fail++;
        $display("FAIL copy_data c%0d r%0d: got %h want %h", collide, a, rd_data, want[a]);
      end
    end
  endtask
  task automatic test_reset_mid_copy();
    copy_req = 1'b1; copy_src = 1'b0; copy_dst = 1'b1;
    step();
    copy_req = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_chk++;
      if (copy_busy !== 1'b0 || copy_done !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_flags k%0d: busy=%b done=%b, want 0 0", k, copy_busy, copy_done);
      end
      step();
    end
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 4; a++) begin
        bank_sel = b[0]; rd_addr = a[1:0];
        #1;
        n_chk++;
        if (rd_data !== 8'h00) begin
          n_fail++;
          $display("FAIL abort_clear b%0d r%0d: got %h want 00", b, a, rd_data);
        end
      end
  endtask
  task automatic test_same_bank();
    wr(1, 0, 8'h3C);
    copy_req = 1'b1; copy_src = 1'b1; copy_dst = 1'b1;
    step();
    copy_req = 1'b0;
    #1;
    n_chk++;
    if (copy_done !== 1'b1 || copy_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL same_bank_n1: done=%b busy=%b, want 1 1", copy_done, copy_busy);
    end
    step();
    bank_sel = 1'b1; rd_addr = 0;
    #1;
    n_chk++;
    if (copy_done !== 1'b0 || copy_busy !== 1'b0 || rd_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL same_bank_n2: done=%b busy=%b r0=%h, want 0 0 3c", copy_done, copy_busy, rd_data);
    end
  endtask
  task automatic test_bypass();
    wr(0, 3, 8'h10);
    bank_sel = 1'b0; rd_addr = 3; rs_addr = 3; w_data = 8'h7F; w_en = 1'b1;
    #1;
    n_chk++;
`ifdef REGFILE_BYPASS_EN
    if (rs_data !== 8'h7F || rd_data !== 8'h10) begin
      n_fail++;
      $display("FAIL bypass_same: rs=%h rd=%h, want 7f 10", rs_data, rd_data);
    end
`else
    if (rs_data !== 8'h10 || rd_data !== 8'h10) begin
      n_fail++;
      $display("FAIL bypass_same: rs=%h rd=%h, want 10 10", rs_data, rd_data);
    end
`endif
    step();
    w_en = 1'b0;
    #1;
    n_chk++;
    if (rs_data !== 8'h7F) begin
      n_fail++;
      $display("FAIL bypass_next: rs=%h want 7f", rs_data);
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) < 2);
      bank_sel = 1'($urandom);
      rd_addr = 2'($urandom);
      rs_addr = 2'($urandom);
      w_data = 8'($urandom);
      w_en = 1'($urandom);
      copy_req = ($urandom_range(0, 9) == 0);
      copy_src = 1'($urandom);
      copy_dst = 1'($urandom);
      #1;
      n_chk++;
      if (rd_data !== m[bank_sel][rd_addr] || rs_data !== exp_rs() || copy_busy !== (m_left > 0 || m_done) || copy_done !== m_done) begin
        n_fail++;
        $display("FAIL random i%0d: rd=%h/%h rs=%h/%h busy=%b/%b done=%b/%b (got/want)", i, rd_data, m[bank_sel][rd_addr],
                 rs_data, exp_rs(), copy_busy, m_left > 0 || m_done, copy_done, m_done);
      end
      step();
    end
    reset = 1'b0; w_en = 1'b0; copy_req = 1'b0;
  endtask
  initial begin
    m_left = 0;
    m_done = 0;
    #1;
    test_reset();
    test_bank_write();
    test_copy(0);
    test_copy(1);
    test_reset_mid_copy();
    test_same_bank();
    test_bypass();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/banked_regfile.md
Name: banked_regfile

Overview:
- Parametrised multi-bank CPU register file. Successor to the two-bank (normal/interrupt) 8-bit x4 file in the jacaranda-8 core.
- Generalises data width, register count and bank count.
- Adds synchronous reset and a hardware bank-copy engine, a small FSM that copies one whole bank into another, used for context save/restore on interrupt entry and exit.
- Sits between decode and ALU. One write port and two asynchronous read ports.

Parameters:
- DATA_W, 8: register width in bits.
- ADDR_W, 2: register address width; registers per bank = 2**ADDR_W.
- BANK_W, 1: bank select width; number of banks = 2**BANK_W.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- bank_sel  input  BANK_W  active bank for reads and CPU writes (0 = normal, 1 = interrupt context).
- rd_addr  input  ADDR_W  destination/first-source register address.
- rs_addr  input  ADDR_W  second-source register address.
- w_data  input  DATA_W  write data.
- w_en  input  1  write enable: register[bank_sel][rd_addr] <= w_data.
- rd_data  output  DATA_W  register[bank_sel][rd_addr], combinational.
- rs_data  output  DATA_W  register[bank_sel][rs_addr], combinational.
- copy_req  input  1  start bank copy; sampled only in IDLE.
- copy_src  input  BANK_W  source bank, latched on accepted copy_req.
- copy_dst  input  BANK_W  destination bank, latched on accepted copy_req.
- copy_busy  output  1  high while state != IDLE.
- copy_done  output  1  one-cycle pulse on completion.

Behaviour:
- Reset:
  - Every register in every bank is cleared to 0.
  - FSM goes to IDLE; copy index goes to 0; copy_busy=0, copy_done=0.
  - Reset mid-copy aborts the copy. No completion pulse is issued.
- Reads: purely combinational, zero latency. A write becomes visible the cycle after the clock edge.
- CPU write: when w_en=1, register[bank_sel][rd_addr] takes w_data at the edge. Permitted in any FSM state.
- FSM states: IDLE, COPY, DONE.
  - IDLE -> COPY: copy_req=1 and copy_src != copy_dst. Latch src and dst; idx <= 0.
  - IDLE -> DONE: copy_req=1 and copy_src == copy_dst. No data is moved.
  - COPY, each cycle: register[dst][idx] <= register[src][idx], with src read in that same cycle. idx increments by 1.
  - COPY -> DONE: the copy of idx = 2**ADDR_W-1 completes the transfer. A copy takes exactly 2**ADDR_W cycles in COPY.
  - DONE -> IDLE: unconditional. copy_done=1 for exactly the DONE cycle.
- Outputs: copy_busy=1 in COPY and DONE. copy_req is ignored while busy; there is no queueing.
- Latency:
  - copy_req accepted at edge N.
  - copy_done high during cycle N+1+2**ADDR_W.
  - For src == dst, copy_done is high during cycle N+1.
- Collisions:
  - CPU write to register[dst][idx] in the same cycle COPY writes it: the CPU write wins.
  - CPU write to a src entry not yet copied: the new value is copied.
  - CPU write to a src entry already copied: not propagated.
  - CPU write to a dst entry already copied: persists.
- Width: idx is ADDR_W+1 bits internally, so the terminal-count compare has no wrap ambiguity. Data is copied bit-exact, with no arithmetic.
- bank_sel may change in any cycle, including mid-copy. It affects only the CPU read and write paths.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. When w_en=1 and rs_addr==rd_addr, rs_data = w_data combinationally in the same cycle, within the same bank. rd_data is never bypassed.
- Undefined: rs_data always reflects stored register contents. The default build matches the old core's timing.

Test Plan:
- Reset, then read every address in both banks -> all rd_data/rs_data = 0x00; copy_busy=0.
- bank_sel=0: write R1=0x5A. bank_sel=1: write R1=0xC3. Read R1 in bank 0 -> 0x5A; in bank 1 -> 0xC3.
- Bank 0 R0..R3 = 0x11,0x22,0x33,0x44. copy_req src=0 dst=1 at edge N -> copy_busy high 5 cycles; copy_done pulses in cycle N+5; bank 1 reads 0x11,0x22,0x33,0x44.
- During the copy, CPU writes bank 1 R2=0xEE in the cycle idx=2 -> bank 1 R2 = 0xEE afterwards. A second copy_req while busy is ignored; there is exactly one copy_done pulse.
- Assert reset at idx=1 mid-copy -> FSM in IDLE, no copy_done, all registers 0x00 next cycle. copy_req with src=dst=1 -> copy_done in cycle N+1, no data change.
- With REGFILE_BYPASS_EN: w_en=1, rd_addr=rs_addr=3, w_data=0x7F -> rs_data=0x7F in the same cycle. Without the macro, rs_data shows the old value until the next cycle.
